// File: rtl/bias_acc_ctrl.sv
// rtl/bias_acc_ctrl.sv - per-lane adder-tree accumulator with bias, saturation and optional ReLU
module bias_acc_ctrl #(
    parameter int N_adder_tree = 16,
    parameter int N_PASS       = 4,
    parameter int N_GROUP      = 8,
    localparam int GW = (N_GROUP > 1) ? $clog2(N_GROUP) : 1,
    localparam int PW = (N_PASS > 1) ? $clog2(N_PASS) : 1,
    localparam int DW = N_adder_tree * 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          relu_en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] bias,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [GW-1:0] group_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

    state_t          state;
    logic [PW-1:0]   pass_cnt;
    logic            relu_q;
    logic [17:0]     acc      [N_adder_tree];
    logic [17:0]     acc_next [N_adder_tree];
    logic [17:0]     biased   [N_adder_tree];

    // Clamp a 19-bit signed sum to the 18-bit range instead of wrapping.
    function automatic logic [17:0] sat18(input logic [18:0] s);
        if (s[18] != s[17]) begin
            return s[18] ? 18'h20000 : 18'h1ffff;
        end
        return s[17:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N_adder_tree; i++) begin
            acc_next[i] = sat18({acc[i][17], acc[i]} +
                                {in_data[18*i+17], in_data[18*i +: 18]});
            biased[i]   = sat18({acc[i][17], acc[i]} +
                                {bias[18*i+17], bias[18*i +: 18]});
            if (relu_q && biased[i][17]) begin
                biased[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pass_cnt  <= '0;
            group_idx <= '0;
            relu_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < N_adder_tree; i++) begin
                acc[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_adder_tree; i++) begin
                            acc[i] <= '0;
                        end
                        pass_cnt  <= '0;
                        group_idx <= '0;
                        relu_q    <= relu_en;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_adder_tree; i++) begin
                            acc[i] <= acc_next[i];
                        end
                        if (pass_cnt == PW'(N_PASS - 1)) begin
                            in_ready <= 1'b0;
                            state    <= BIAS;
                        end else begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end
                end
                BIAS: begin
                    for (int i = 0; i < N_adder_tree; i++) begin
                        out_data[18*i +: 18] <= biased[i];
                    end
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pass_cnt  <= '0;
                        if (group_idx != GW'(N_GROUP - 1)) begin
                            for (int i = 0; i < N_adder_tree; i++) begin
                                acc[i] <= '0;
                            end
                            group_idx <= group_idx + 1'b1;
                            in_ready  <= 1'b1;
                            state     <= ACCUM;
                        end else begin
                            group_idx <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_acc_ctrl.sv
// tb/tb_bias_acc_ctrl.sv - scoreboard bench for bias_acc_ctrl with a lane-arithmetic reference model
module tb_bias_acc_ctrl;
    localparam int NL = 16;
    localparam int NP = 4;
    localparam int NG = 8;
    localparam int W  = NL * 18;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         relu_en = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, busy, done;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] bias = '0;
    logic [W-1:0] out_data;
    logic [2:0]   group_idx;

    bias_acc_ctrl #(.N_adder_tree(NL), .N_PASS(NP), .N_GROUP(NG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .group_idx(group_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           gidx;
        int           beat_cyc;
        bit           last;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] beats[$];
    int           checks = 0;
    int           passes = 0;
    int           cyc = 0;
    int           stall_mode = 0;
    int           acc_m[NL];
    int           gcnt = 0;
    bit           relu_lat = 0;
    bit           exp_done = 0;
    int           done_cnt = 0;
    bit           first_seen = 0;
    logic [W-1:0] first_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic int lane(input logic [W-1:0] v, input int i);
        logic signed [17:0] x;
        x = v[18*i +: 18];
        return int'(x);
    endfunction

    function automatic int clamp(input int v);
        return (v > 131071) ? 131071 : ((v < -131072) ? -131072 : v);
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] v;
        for (int i = 0; i < NL; i++) begin
            case ($urandom_range(0, 3))
                0: v[18*i +: 18] = 18'($urandom);
                1: v[18*i +: 18] = 18'(100000 + $urandom_range(0, 31071));
                2: v[18*i +: 18] = 18'(-100000 - int'($urandom_range(0, 31072)));
                default: v[18*i +: 18] = 18'(int'($urandom_range(0, 2000)) - 1000);
            endcase
        end
        return v;
    endfunction

    task automatic fill_beats();
        beats.delete();
        for (int k = 0; k < NG * NP; k++) beats.push_back(rand_beat());
        bias = rand_beat();
    endtask

    task automatic set_lane(input int k, input int ln, input int val);
        logic [W-1:0] t;
        t = beats[k];
        t[18*ln +: 18] = 18'(val);
        beats[k] = t;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) acc_m[i] = 0;
    endtask

    // One output group: lane sums already saturated per beat, then bias, then optional ReLU.
    task automatic model_group(input int bcyc);
        exp_t e;
        int   s;
        for (int i = 0; i < NL; i++) begin
            s = clamp(acc_m[i] + lane(bias, i));
            if (relu_lat && s < 0) s = 0;
            e.data[18*i +: 18] = 18'(s);
        end
        e.gidx = gcnt;
        e.beat_cyc = bcyc;
        e.last = (gcnt == NG - 1);
        sb.push_back(e);
        gcnt++;
        model_clear();
    endtask

    initial forever begin : ready_driver
        int vcnt;
        @(posedge clk);
        #1;
        if (out_valid) vcnt++;
        else vcnt = 0;
        if (stall_mode != 0) out_ready = (vcnt >= 6);
        else out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin : monitor
        bit           holding;
        logic [W-1:0] held_d;
        logic [2:0]   held_g;
        exp_t         e;
        if (!rst_n) begin
            holding = 0;
            exp_done = 0;
        end else begin
            if (done) done_cnt++;
            if (done || exp_done) chk("done_pulse", W'(done), W'(exp_done));
            exp_done = 0;
            if (out_valid) begin
                if (!holding) begin
                    holding = 1;
                    held_d = out_data;
                    held_g = group_idx;
                    if (!first_seen) begin
                        first_seen = 1;
                        first_out = out_data;
                    end
                    if (sb.size() == 0) chk("unexpected_output", W'(1), W'(0));
                    else chk("latency", W'(cyc - sb[0].beat_cyc), W'(2));
                end else begin
                    chk("stall_data_stable", out_data, held_d);
                    chk("stall_gidx_stable", W'(group_idx), W'(held_g));
                end
                if (out_ready) begin
                    holding = 0;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("group_idx", W'(group_idx), W'(e.gidx));
                        if (e.last) exp_done = 1;
                    end
                end
            end
        end
    end

    task automatic run_layer(input bit relu, input int smode, input int abort_at);
        int nacc;
        int bud;
        int done0;
        nacc = 0;
        bud = 0;
        stall_mode = smode;
        first_seen = 0;
        done0 = done_cnt;
        @(posedge clk); #1;
        relu_en = relu;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        relu_en = ~relu;
        relu_lat = relu;
        gcnt = 0;
        model_clear();
        chk("start_busy_ready", W'({busy, in_ready}), W'(2'b11));
        while (nacc < NG * NP && bud < 5000) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data = in_valid ? beats[0] : rand_beat();
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                for (int i = 0; i < NL; i++) acc_m[i] = clamp(acc_m[i] + lane(in_data, i));
                void'(beats.pop_front());
                nacc++;
                if (nacc % NP == 0) model_group(cyc);
                if (abort_at >= 0 && nacc == abort_at) begin
                    @(posedge clk); #1;
                    chk("abort_group_idx", W'(group_idx), W'(abort_at / NP));
                    rst_n = 0;
                    start = 0;
                    in_valid = 0;
                    #1;
                    chk("abort_ctrl_zero", W'({in_ready, out_valid, busy, done, group_idx}), '0);
                    chk("abort_data_zero", out_data, '0);
                    @(negedge clk);
                    rst_n = 1;
                    sb.delete();
                    model_clear();
                    repeat (3) @(posedge clk);
                    #1;
                    chk("abort_stays_idle", W'({busy, in_ready, out_valid}), '0);
                    return;
                end
            end
            @(posedge clk); #1;
            bud++;
        end
        in_valid = 0;
        start = 0;
        chk("beat_timeout", W'(bud >= 5000), '0);
        bud = 0;
        while ((sb.size() != 0 || busy) && bud < 3000) begin
            @(posedge clk);
            bud++;
        end
        chk("drain_timeout", W'(bud >= 3000), '0);
        repeat (2) @(posedge clk);
        #1;
        chk("done_count", W'(done_cnt - done0), W'(1));
        chk("idle_after_run", W'({busy, in_ready, out_valid}), '0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", W'({in_ready, out_valid, busy, done, group_idx}), '0);
        chk("reset_data", out_data, '0);
        rst_n = 1;

        fill_beats();
        set_lane(0, 0, 100); set_lane(1, 0, 200); set_lane(2, 0, -50); set_lane(3, 0, 10);
        bias[0 +: 18] = 18'(1000);
        run_layer(0, 0, -1);
        chk("sum_bias_lane0", W'(lane(first_out, 0)), W'(1260));

        fill_beats();
        for (int k = 0; k < NP; k++) set_lane(k, 0, 100000);
        bias[0 +: 18] = 18'(-10);
        run_layer(0, 1, -1);
        chk("sat_pos_lane0", W'(lane(first_out, 0)), W'(131061));

        fill_beats();
        for (int k = 0; k < NP; k++) set_lane(k, 0, -100000);
        bias[0 +: 18] = 18'(-1);
        run_layer(0, 0, -1);
        chk("sat_neg_lane0", W'(lane(first_out, 0)), W'(-131072));

        fill_beats();
        for (int k = 0; k < NP; k++) begin
            set_lane(k, 0, -125);
            set_lane(k, 1, 75);
        end
        bias[0 +: 18] = 18'b111111111110111000;
        bias[18 +: 18] = 18'(5188);
        run_layer(1, 0, -1);
        chk("relu_lane0", W'(lane(first_out, 0)), W'(0));
        chk("relu_lane1", W'(lane(first_out, 1)), W'(5488));

        fill_beats();
        run_layer(1, 1, -1);

        fill_beats();
        run_layer(0, 0, 3 * NP + 2);

        fill_beats();
        run_layer(0, 1, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
